// File: rtl/exc_req_ctrl_pkg.sv
// Shared exception definitions: controller states, cause codes, pending-bit layout.
// Used by the request controller, the exception unit and decode.
package exc_pkg;

  typedef enum logic [1:0] {IDLE, REQ, HANDLER} exc_state_t;

  localparam logic [3:0] CAUSE_NONE   = 4'h0;
  localparam logic [3:0] CAUSE_INVOP  = 4'h1;
  localparam logic [3:0] CAUSE_EXTIRQ = 4'h2;
  localparam logic [3:0] CAUSE_TIMER  = 4'h3;

  localparam int unsigned PEND_INVOP = 0;
  localparam int unsigned PEND_EXT   = 1;
  localparam int unsigned PEND_TIMER = 2;
  localparam int unsigned PEND_W     = 3;

  // Fixed priority INVOP > TIMER > EXTIRQ
  function automatic logic [3:0] exc_cause(input logic [PEND_W-1:0] pend);
    if (pend[PEND_INVOP]) return CAUSE_INVOP;
    if (pend[PEND_TIMER]) return CAUSE_TIMER;
    if (pend[PEND_EXT])   return CAUSE_EXTIRQ;
    return CAUSE_NONE;
  endfunction

  function automatic logic [PEND_W-1:0] cause_mask(input logic [3:0] cause);
    logic [PEND_W-1:0] m;
    m = '0;
    case (cause)
      CAUSE_INVOP:  m[PEND_INVOP] = 1'b1;
      CAUSE_EXTIRQ: m[PEND_EXT]   = 1'b1;
      CAUSE_TIMER:  m[PEND_TIMER] = 1'b1;
      default:      m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/exc_req_ctrl_if.sv
// Signal bundle between the exception sources/exception unit (master) and
// the request controller (slave).
interface exc_req_ctrl_if;
  logic       InvOp_E;
  logic       ExtIRQ;
  logic       TimerEn;
  logic       ExcAck;
  logic       ERet;
  logic       Exc;
  logic [3:0] EStatus;
  logic [2:0] Pending;

  modport master (
    output InvOp_E, ExtIRQ, TimerEn, ExcAck, ERet,
    input  Exc, EStatus, Pending
  );

  modport slave (
    input  InvOp_E, ExtIRQ, TimerEn, ExcAck, ERet,
    output Exc, EStatus, Pending
  );
endinterface

// File: rtl/exc_req_ctrl_timer.sv
// Periodic tick source: counts 0..TIMER_PERIOD-1 while enabled, holds when not,
// and flags the wrap cycle on tick_o. Only instantiated with EXC_TIMER_EN.
module exc_timer #(
  parameter int unsigned TIMER_PERIOD = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned CNT_W = $clog2(TIMER_PERIOD);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMER_PERIOD - 1);

  logic [CNT_W-1:0] count_q, count_d;

  assign tick_o = en_i && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = (count_q == LAST) ? '0 : count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/exc_req_ctrl.sv
// Exception request controller: latches InvOp/ExtIRQ/timer events, arbitrates by
// fixed priority and handshakes with the exception unit. Timer source: EXC_TIMER_EN.
module exc_req_ctrl
  import exc_pkg::*;
#(
  parameter int unsigned TIMER_PERIOD = 1000
) (
  input logic           clk,
  input logic           reset,
  exc_req_ctrl_if.slave bus
);

  logic              s1_q, s2_q, s3_q;
  logic              ext_edge;
  logic              timer_tick;
  logic [PEND_W-1:0] pend_set, pend_clr;
  logic [PEND_W-1:0] pending_q, pending_d;
  exc_state_t        state_q;
  logic              exc_q;
  logic [3:0]        estatus_q;

`ifdef EXC_TIMER_EN
  exc_timer #(.TIMER_PERIOD(TIMER_PERIOD)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .en_i   (bus.TimerEn),
    .tick_o (timer_tick)
  );
`else
  localparam int unsigned unused_period = TIMER_PERIOD;
  logic unused_timer_en;
  assign unused_timer_en = bus.TimerEn;
  assign timer_tick      = 1'b0;
`endif

  assign ext_edge = s2_q & ~s3_q;

  // Set beats clear so an event arriving on the acknowledge cycle is kept
  always_comb begin
    pend_set             = '0;
    pend_set[PEND_INVOP] = bus.InvOp_E;
    pend_set[PEND_EXT]   = ext_edge;
    pend_set[PEND_TIMER] = timer_tick;
    pend_clr             = '0;
    if ((state_q == REQ) && bus.ExcAck) begin
      pend_clr = cause_mask(estatus_q);
    end
    pending_d = (pending_q & ~pend_clr) | pend_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      pending_q <= '0;
    end else begin
      s1_q      <= bus.ExtIRQ;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      exc_q     <= 1'b0;
      estatus_q <= CAUSE_NONE;
    end else begin
      case (state_q)
        IDLE: begin
          if (|pending_q) begin
            state_q   <= REQ;
            exc_q     <= 1'b1;
            estatus_q <= exc_cause(pending_q);
          end
        end
        REQ: begin
          if (bus.ExcAck) begin
            state_q <= HANDLER;
            exc_q   <= 1'b0;
          end
        end
        HANDLER: begin
          if (bus.ERet) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          exc_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Exc     = exc_q;
  assign bus.EStatus = estatus_q;
  assign bus.Pending = pending_q;

endmodule

// File: tb/tb_exc_req_ctrl.sv
// Self-checking bench for exc_req_ctrl: directed scenarios plus randomized traffic
// against an event-level reference model. Timer scenario needs EXC_TIMER_EN.
module tb_exc_req_ctrl;

  localparam int PERIOD = 8;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  exc_req_ctrl_if bus ();

  exc_req_ctrl #(.TIMER_PERIOD(PERIOD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: pending flags, request phase (0 idle, 1 requesting, 2 in handler)
  bit       m_pend[3];
  int       m_phase;
  bit [3:0] m_cause;
  bit       hist[$];
  int       m_tcount;
  int       prio[3] = '{0, 2, 1};

  function automatic void model_edge();
    bit ev[3];
    bit was[3];
    bit taken;
    int ack_idx;
    bit found;
    if (reset) begin
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_phase  = 0;
      m_cause  = 4'h0;
      hist     = {1'b0, 1'b0, 1'b0};
      m_tcount = 0;
      return;
    end
    was   = m_pend;
    ev[0] = bus.InvOp_E;
    ev[1] = hist[1] && !hist[0];
    ev[2] = 1'b0;
`ifdef EXC_TIMER_EN
    if (bus.TimerEn) begin
      if (m_tcount == PERIOD - 1) begin
        ev[2]    = 1'b1;
        m_tcount = 0;
      end else begin
        m_tcount++;
      end
    end
`endif
    hist.push_back(bus.ExtIRQ);
    void'(hist.pop_front());
    taken   = (m_phase == 1) && bus.ExcAck;
    ack_idx = int'(m_cause) - 1;
    for (int i = 0; i < 3; i++) begin
      m_pend[i] = ev[i] || (was[i] && !(taken && ack_idx == i));
    end
    case (m_phase)
      0: begin
        found = 1'b0;
        for (int k = 0; k < 3; k++) begin
          if (!found && was[prio[k]]) begin
            found   = 1'b1;
            m_cause = 4'(prio[k] + 1);
            m_phase = 1;
          end
        end
      end
      1: if (bus.ExcAck) m_phase = 2;
      default: if (bus.ERet) m_phase = 0;
    endcase
  endfunction

  function automatic logic [7:0] model_vec();
    return {(m_phase == 1) ? 1'b1 : 1'b0, m_cause, m_pend[2], m_pend[1], m_pend[0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.ExtIRQ  = 1'b1;
    bus.InvOp_E = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({bus.Exc, bus.EStatus, bus.Pending} !== 8'h00) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got=%h exp=00", cyc, {bus.Exc, bus.EStatus, bus.Pending});
      end
    end
    reset = 1'b0;
    bus.ExtIRQ  = 1'b0;
    bus.InvOp_E = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if ({bus.Exc, bus.EStatus, bus.Pending} !== 8'h00) begin
        bad++;
        $display("FAIL reset_release cyc=%0d got=%h exp=00", cyc, {bus.Exc, bus.EStatus, bus.Pending});
      end
    end
  endtask

  task automatic test_invop();
    bus.InvOp_E = 1'b1;
    tick();
    bus.InvOp_E = 1'b0;
    total++;
    if (bus.Pending !== 3'b001 || bus.Exc !== 1'b0) begin
      bad++;
      $display("FAIL invop_pend got=%b/%b exp=001/0", bus.Pending, bus.Exc);
    end
    for (int c = 2; c <= 5; c++) begin
      tick();
      total++;
      if (bus.Exc !== 1'b1 || bus.EStatus !== 4'h1) begin
        bad++;
        $display("FAIL invop_req c=%0d got=%b/%h exp=1/1", c, bus.Exc, bus.EStatus);
      end
    end
    bus.ExcAck = 1'b1;
    tick();
    bus.ExcAck = 1'b0;
    total++;
    if (bus.Exc !== 1'b0 || bus.Pending !== 3'b000 || bus.EStatus !== 4'h1) begin
      bad++;
      $display("FAIL invop_ack got=%b/%b/%h exp=0/000/1", bus.Exc, bus.Pending, bus.EStatus);
    end
    tick();
    tick();
    bus.ERet = 1'b1;
    tick();
    bus.ERet = 1'b0;
    tick();
    total++;
    if (bus.Exc !== 1'b0 || bus.Pending !== 3'b000) begin
      bad++;
      $display("FAIL invop_eret got=%b/%b exp=0/000", bus.Exc, bus.Pending);
    end
  endtask

  task automatic test_simultaneous();
    bus.ExtIRQ = 1'b1;
    tick();
    tick();
    bus.InvOp_E = 1'b1;
    tick();
    bus.InvOp_E = 1'b0;
    total++;
    if (bus.Pending !== 3'b011) begin
      bad++;
      $display("FAIL simul_pend got=%b exp=011", bus.Pending);
    end
    tick();
    total++;
    if (bus.Exc !== 1'b1 || bus.EStatus !== 4'h1) begin
      bad++;
      $display("FAIL simul_first got=%b/%h exp=1/1", bus.Exc, bus.EStatus);
    end
    bus.ExcAck = 1'b1;
    tick();
    bus.ExcAck = 1'b0;
    total++;
    if (bus.Exc !== 1'b0 || bus.Pending !== 3'b010) begin
      bad++;
      $display("FAIL simul_ack1 got=%b/%b exp=0/010", bus.Exc, bus.Pending);
    end
    bus.ERet = 1'b1;
    tick();
    bus.ERet = 1'b0;
    tick();
    total++;
    if (bus.Exc !== 1'b1 || bus.EStatus !== 4'h2) begin
      bad++;
      $display("FAIL simul_second got=%b/%h exp=1/2", bus.Exc, bus.EStatus);
    end
    bus.ExcAck = 1'b1;
    tick();
    bus.ExcAck = 1'b0;
    bus.ERet   = 1'b1;
    tick();
    bus.ERet   = 1'b0;
    bus.ExtIRQ = 1'b0;
    tick();
    tick();
    total++;
    if (bus.Exc !== 1'b0 || bus.Pending !== 3'b000) begin
      bad++;
      $display("FAIL simul_idle got=%b/%b exp=0/000", bus.Exc, bus.Pending);
    end
  endtask

  task automatic test_handler_irq();
    bus.InvOp_E = 1'b1;
    tick();
    bus.InvOp_E = 1'b0;
    tick();
    bus.ExcAck = 1'b1;
    tick();
    bus.ExcAck = 1'b0;
    bus.ExtIRQ = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i == 2) bus.ExtIRQ = 1'b0;
      tick();
      total++;
      if (bus.Exc !== 1'b0) begin
        bad++;
        $display("FAIL handler_quiet i=%0d got=%b exp=0", i, bus.Exc);
      end
    end
    total++;
    if (bus.Pending[1] !== 1'b1) begin
      bad++;
      $display("FAIL handler_pend got=%b exp=1", bus.Pending[1]);
    end
    bus.ERet = 1'b1;
    tick();
    bus.ERet = 1'b0;
    total++;
    if (bus.Exc !== 1'b0) begin
      bad++;
      $display("FAIL b2b_k1 got=%b exp=0", bus.Exc);
    end
    tick();
    total++;
    if (bus.Exc !== 1'b1 || bus.EStatus !== 4'h2) begin
      bad++;
      $display("FAIL b2b_k2 got=%b/%h exp=1/2", bus.Exc, bus.EStatus);
    end
    bus.ExcAck = 1'b1;
    tick();
    bus.ExcAck = 1'b0;
    bus.ERet   = 1'b1;
    tick();
    bus.ERet   = 1'b0;
    tick();
    // ERet while idle must be ignored
    bus.ERet = 1'b1;
    tick();
    bus.ERet = 1'b0;
    total++;
    if (bus.Exc !== 1'b0 || bus.Pending !== 3'b000 || bus.EStatus !== 4'h2) begin
      bad++;
      $display("FAIL eret_idle got=%b/%b/%h exp=0/000/2", bus.Exc, bus.Pending, bus.EStatus);
    end
    // ExcAck while idle with a pending bit must be ignored
    bus.InvOp_E = 1'b1;
    tick();
    bus.InvOp_E = 1'b0;
    bus.ExcAck  = 1'b1;
    tick();
    bus.ExcAck  = 1'b0;
    total++;
    if (bus.Exc !== 1'b1 || bus.EStatus !== 4'h1 || bus.Pending !== 3'b001) begin
      bad++;
      $display("FAIL ack_idle got=%b/%h/%b exp=1/1/001", bus.Exc, bus.EStatus, bus.Pending);
    end
    bus.ExcAck = 1'b1;
    tick();
    bus.ExcAck = 1'b0;
    bus.ERet   = 1'b1;
    tick();
    bus.ERet   = 1'b0;
    tick();
  endtask

  task automatic test_set_clear();
    bus.InvOp_E = 1'b1;
    tick();
    bus.InvOp_E = 1'b0;
    tick();
    bus.ExcAck  = 1'b1;
    bus.InvOp_E = 1'b1;
    tick();
    bus.ExcAck  = 1'b0;
    bus.InvOp_E = 1'b0;
    total++;
    if (bus.Pending[0] !== 1'b1 || bus.Exc !== 1'b0) begin
      bad++;
      $display("FAIL set_wins got=%b/%b exp=1/0", bus.Pending[0], bus.Exc);
    end
    bus.ERet = 1'b1;
    tick();
    bus.ERet = 1'b0;
    tick();
    total++;
    if (bus.Exc !== 1'b1 || bus.EStatus !== 4'h1) begin
      bad++;
      $display("FAIL set_wins_req got=%b/%h exp=1/1", bus.Exc, bus.EStatus);
    end
    bus.ExcAck = 1'b1;
    tick();
    bus.ExcAck = 1'b0;
    bus.ERet   = 1'b1;
    tick();
    bus.ERet   = 1'b0;
    tick();
  endtask

  task automatic test_timer();
    int  last_rise;
    int  n_rise;
    int  freeze_rises;
    bit  prev;
    bit  got;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.TimerEn = 1'b1;
    last_rise = -1;
    n_rise    = 0;
    prev      = 1'b0;
`ifdef EXC_TIMER_EN
    for (int i = 0; i < 60 && n_rise < 4; i++) begin
      bus.ExcAck = (m_phase == 1);
      bus.ERet   = (m_phase == 2);
      tick();
      total++;
      if ({bus.Exc, bus.EStatus, bus.Pending} !== model_vec()) begin
        bad++;
        $display("FAIL timer_model cyc=%0d got=%h exp=%h", cyc, {bus.Exc, bus.EStatus, bus.Pending}, model_vec());
      end
      if (bus.Exc && !prev) begin
        total++;
        if (bus.EStatus !== 4'h3) begin
          bad++;
          $display("FAIL timer_cause got=%h exp=3", bus.EStatus);
        end
        if (last_rise >= 0) begin
          total++;
          if (cyc - last_rise != PERIOD) begin
            bad++;
            $display("FAIL timer_period got=%0d exp=%0d", cyc - last_rise, PERIOD);
          end
        end
        last_rise = cyc;
        n_rise++;
      end
      prev = bus.Exc;
    end
    total++;
    if (n_rise != 4) begin
      bad++;
      $display("FAIL timer_count got=%0d exp=4", n_rise);
    end
    bus.TimerEn  = 1'b0;
    freeze_rises = 0;
    for (int i = 0; i < 20; i++) begin
      bus.ExcAck = (m_phase == 1);
      bus.ERet   = (m_phase == 2);
      tick();
      if (bus.Exc && !prev) freeze_rises++;
      prev = bus.Exc;
    end
    total++;
    if (freeze_rises != 0 || bus.Pending[2] !== 1'b0) begin
      bad++;
      $display("FAIL timer_freeze got=%0d/%b exp=0/0", freeze_rises, bus.Pending[2]);
    end
    bus.TimerEn = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      bus.ExcAck = (m_phase == 1);
      bus.ERet   = (m_phase == 2);
      tick();
      if (bus.Exc && !prev) begin
        got = 1'b1;
        total++;
        if (cyc - last_rise != PERIOD + 20 || bus.EStatus !== 4'h3) begin
          bad++;
          $display("FAIL timer_resume got=%0d/%h exp=%0d/3", cyc - last_rise, bus.EStatus, PERIOD + 20);
        end
      end
      prev = bus.Exc;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL timer_resume_timeout got=none exp=request");
    end
`else
    for (int i = 0; i < 5 * PERIOD; i++) begin
      bus.ExcAck = (m_phase == 1);
      bus.ERet   = (m_phase == 2);
      bus.InvOp_E = ($urandom_range(0, 7) == 0);
      tick();
      total++;
      if (bus.Pending[2] !== 1'b0 || bus.EStatus === 4'h3) begin
        bad++;
        $display("FAIL no_timer cyc=%0d got=%b/%h exp=0/not3", cyc, bus.Pending[2], bus.EStatus);
      end
    end
    bus.InvOp_E = 1'b0;
`endif
    bus.TimerEn = 1'b0;
    bus.ExcAck  = 1'b0;
    bus.ERet    = 1'b0;
  endtask

  task automatic test_random();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 800; i++) begin
      reset       = ($urandom_range(0, 199) == 0);
      bus.InvOp_E = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 5) == 0) bus.ExtIRQ = ~bus.ExtIRQ;
      bus.ExcAck  = ($urandom_range(0, 2) == 0);
      bus.ERet    = ($urandom_range(0, 2) == 0);
      bus.TimerEn = ($urandom_range(0, 1) == 0);
      tick();
      total++;
      if ({bus.Exc, bus.EStatus, bus.Pending} !== model_vec()) begin
        bad++;
        $display("FAIL random cyc=%0d got=%h exp=%h", cyc, {bus.Exc, bus.EStatus, bus.Pending}, model_vec());
      end
    end
    reset       = 1'b0;
    bus.InvOp_E = 1'b0;
    bus.ExcAck  = 1'b0;
    bus.ERet    = 1'b0;
    bus.TimerEn = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    bus.InvOp_E = 1'b0;
    bus.ExtIRQ  = 1'b0;
    bus.TimerEn = 1'b0;
    bus.ExcAck  = 1'b0;
    bus.ERet    = 1'b0;
    test_reset();
    test_invop();
    test_simultaneous();
    test_handler_irq();
    test_set_clear();
    test_timer();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
